// File: rtl/bus_mem_io_pkg.sv
// Shared constants for the bus_mem_io page-1 slave: I/O register offsets,
// STATUS bit positions and the address-region decode.
package bus_mem_io_pkg;

    localparam logic [7:0] ADDR_TXDATA = 8'hF0;
    localparam logic [7:0] ADDR_STATUS = 8'hF1;
    localparam logic [7:0] ADDR_TMR_LO = 8'hF2;
    localparam logic [7:0] ADDR_TMR_HI = 8'hF3;

    // STATUS = {ovf, empty, full, 1'b0, count[3:0]}
    localparam int STS_OVF   = 7;
    localparam int STS_EMPTY = 6;
    localparam int STS_FULL  = 5;

    typedef enum logic [1:0] {
        REG_ROM,
        REG_RAM,
        REG_IO
    } region_e;

    function automatic region_e decode_region(input logic [8:0] ab, input logic [3:0] io_page);
        if (!ab[8]) return REG_ROM;
        if (ab[7:4] == io_page) return REG_IO;
        return REG_RAM;
    endfunction

endpackage

// File: rtl/bus_mem_io_fifo.sv
// Synchronous circular-buffer FIFO; a push into a full FIFO is accepted only
// when a pop happens on the same edge, otherwise it is reported on drop.
module bus_mem_io_fifo #(
    parameter int  DEPTH = 8,
    parameter int  WIDTH = 8,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             r_clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             drop
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign dout    = empty ? '0 : mem[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count and pointers qualify its contents.
    always_ff @(posedge r_clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/bus_mem_io.sv
// Core-bus memory/IO slave: ROM pass-through, page-1 stack RAM and an I/O window
// with TX FIFO + STATUS. Define BUS_MEM_IO_TIMER_EN to add the snapshot timer at 0x1F2/0x1F3.
module bus_mem_io
    import bus_mem_io_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [3:0] IO_PAGE    = 4'hF
) (
    input  logic       r_clk,
    input  logic       reset,
    input  logic [8:0] ab,
    input  logic [7:0] wdata,
    input  logic       we,
    output logic [7:0] rdata,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    region_e       region;
    logic          io_wr;
    logic          wr_ram, wr_tx, wr_status;
    logic [7:0]    ram_mem [256];
    logic [7:0]    status;
    logic [7:0]    tmr_lo, tmr_hi;
    logic          ovf_q, ovf_d;
    logic          fifo_full, fifo_empty, fifo_drop;
    logic [CW-1:0] fifo_count;
    logic [4:0]    count_ext;

    assign region    = decode_region(ab, IO_PAGE);
    assign rom_addr  = ab[7:0];
    assign io_wr     = we && (region == REG_IO);
    assign wr_ram    = we && (region == REG_RAM);
    assign wr_tx     = io_wr && (ab[3:0] == ADDR_TXDATA[3:0]);
    assign wr_status = io_wr && (ab[3:0] == ADDR_STATUS[3:0]);
    assign tx_valid  = !fifo_empty;
    assign count_ext = 5'(fifo_count);

    bus_mem_io_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .r_clk (r_clk),
        .reset (reset),
        .push  (wr_tx),
        .pop   (tx_ready),
        .din   (wdata),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .drop  (fifo_drop)
    );

    always_ff @(posedge r_clk) begin
        if (wr_ram) ram_mem[ab[7:0]] <= wdata;
    end

    // Drop and clear can never coincide: they need different addresses on one bus cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (fifo_drop) ovf_d = 1'b1;
        if (wr_status) ovf_d = 1'b0;
    end

    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

`ifdef BUS_MEM_IO_TIMER_EN
    logic        wr_tmr;
    logic [15:0] tmr_q, tmr_d;
    logic [15:0] tmr_latch_q, tmr_latch_d;

    assign wr_tmr = io_wr && (ab[3:0] == ADDR_TMR_LO[3:0]);

    always_comb begin
        tmr_d       = tmr_q + 16'd1;
        tmr_latch_d = wr_tmr ? tmr_q : tmr_latch_q;
    end

    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            tmr_q       <= '0;
            tmr_latch_q <= '0;
        end else begin
            tmr_q       <= tmr_d;
            tmr_latch_q <= tmr_latch_d;
        end
    end

    assign tmr_lo = tmr_latch_q[7:0];
    assign tmr_hi = tmr_latch_q[15:8];
`else
    assign tmr_lo = 8'h00;
    assign tmr_hi = 8'h00;
`endif

    always_comb begin
        status            = '0;
        status[STS_OVF]   = ovf_q;
        status[STS_EMPTY] = fifo_empty;
        status[STS_FULL]  = fifo_full;
        status[3:0]       = count_ext[3:0];
    end

    always_comb begin
        rdata = 8'h00;
        case (region)
            REG_ROM: rdata = rom_data;
            REG_RAM: rdata = ram_mem[ab[7:0]];
            REG_IO: begin
                case (ab[3:0])
                    ADDR_STATUS[3:0]: rdata = status;
                    ADDR_TMR_LO[3:0]: rdata = tmr_lo;
                    ADDR_TMR_HI[3:0]: rdata = tmr_hi;
                    default:          rdata = 8'h00;
                endcase
            end
            default: rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_bus_mem_io.sv
// Self-checking bench for bus_mem_io: directed scenarios plus random bus traffic
// compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_bus_mem_io;

    localparam int DEPTH = 8;

    logic       r_clk = 1'b0;
    logic       reset;
    logic [8:0] ab;
    logic [7:0] wdata;
    logic       we;
    logic [7:0] rdata;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [7:0]  mq [$];
    logic [7:0]  obs [$];
    logic        mdl_ovf;
    logic [15:0] mdl_tmr;
    logic [15:0] mdl_latch;
    logic [7:0]  mdl_ram [256];
    bit          mdl_ram_ok [256];

    bus_mem_io #(
        .FIFO_DEPTH (DEPTH),
        .IO_PAGE    (4'hF)
    ) dut (
        .r_clk    (r_clk),
        .reset    (reset),
        .ab       (ab),
        .wdata    (wdata),
        .we       (we),
        .rdata    (rdata),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #10 r_clk = ~r_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        int sz = mq.size();
        return {mdl_ovf, sz == 0, sz == DEPTH, 1'b0, 4'(sz)};
    endfunction

    function automatic logic [7:0] exp_rdata(input logic [8:0] a, output bit known);
        known = 1'b1;
        if (!a[8]) return rom_data;
        if (a[7:4] != 4'hF) begin
            known = mdl_ram_ok[a[7:0]];
            return mdl_ram[a[7:0]];
        end
        case (a[3:0])
            4'h1: return exp_status();
`ifdef BUS_MEM_IO_TIMER_EN
            4'h2: return mdl_latch[7:0];
            4'h3: return mdl_latch[15:8];
`endif
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        mdl_ovf   = 1'b0;
        mdl_tmr   = '0;
        mdl_latch = '0;
        foreach (mdl_ram_ok[i]) mdl_ram_ok[i] = 1'b0;
    endtask

    // Effect of one rising edge, using the inputs present at that edge.
    task automatic model_edge();
        if (mq.size() != 0 && tx_ready) void'(mq.pop_front());
        if (we && ab == 9'h1F0) begin
            if (mq.size() < DEPTH) mq.push_back(wdata);
            else mdl_ovf = 1'b1;
        end
        if (we && ab == 9'h1F1) mdl_ovf = 1'b0;
        if (we && ab[8] && ab[7:4] != 4'hF) begin
            mdl_ram[ab[7:0]]    = wdata;
            mdl_ram_ok[ab[7:0]] = 1'b1;
        end
`ifdef BUS_MEM_IO_TIMER_EN
        if (we && ab == 9'h1F2) mdl_latch = mdl_tmr;
`endif
        mdl_tmr = mdl_tmr + 16'd1;
    endtask

    task automatic step();
        if (tx_valid && tx_ready) obs.push_back(tx_data);
        @(posedge r_clk);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic wr(input logic [8:0] a, input logic [7:0] d);
        ab = a; wdata = d; we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic peek(input logic [8:0] a);
        ab = a; we = 1'b0;
        #1;
    endtask

    task automatic check_outputs(input string tag);
        bit         known;
        logic [7:0] e;
        #1;
        e = exp_rdata(ab, known);
        if (known) check({tag, ".rdata"}, rdata, e);
        check({tag, ".rom_addr"}, rom_addr, ab[7:0]);
        check({tag, ".tx_valid"}, tx_valid, mq.size() != 0);
        check({tag, ".tx_data"}, tx_data, (mq.size() != 0) ? mq[0] : 8'h00);
    endtask

    task automatic drain_all(input string tag);
        tx_ready = 1'b1;
        we = 1'b0;
        for (int k = 0; k < 40 && mq.size() != 0; k++) begin
            check_outputs(tag);
            step();
        end
        tx_ready = 1'b0;
        #1;
        check({tag, ".empty"}, tx_valid, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1; we = 1'b0; tx_ready = 1'b0;
        #1;
        model_reset();
        repeat (2) @(posedge r_clk);
        #3;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        logic [7:0] drain_exp [3];
        int         kind;

        reset = 1'b0; ab = '0; wdata = '0; we = 1'b0; rom_data = '0; tx_ready = 1'b0;
        model_reset();
        do_reset();

        // Reset state and ROM pass-through
        ab = 9'h005; rom_data = 8'hA7;
        #1;
        check("rom_rdata", rdata, 8'hA7);
        check("rom_addr", rom_addr, 8'h05);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        peek(9'h1F1);
        check("rst_status", rdata, 8'h40);

        // RAM write/read; ROM-region write ignored
        wr(9'h120, 8'h3C);
        peek(9'h120);
        check("ram_rd", rdata, 8'h3C);
        wr(9'h020, 8'h99);
        peek(9'h120);
        check("ram_keep", rdata, 8'h3C);
        peek(9'h1F1);
        check("rom_wr_status", rdata, 8'h40);

        // Three pushes, then in-order drain
        drain_exp[0] = 8'h11; drain_exp[1] = 8'h22; drain_exp[2] = 8'h33;
        for (int i = 0; i < 3; i++) wr(9'h1F0, drain_exp[i]);
        peek(9'h1F1);
        check("push3_status", rdata, 8'h03);
        check("push3_head", tx_data, 8'h11);
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("drain3_data", tx_data, drain_exp[i]);
            check("drain3_valid", tx_valid, 1'b1);
            step();
        end
        tx_ready = 1'b0;
        #1;
        check("drain3_done", tx_valid, 1'b0);

        // Overflow, sticky flag, clear, push-while-full-with-pop
        for (int i = 0; i < 8; i++) wr(9'h1F0, 8'h40 + 8'(i));
        peek(9'h1F1);
        check("full_status", rdata, 8'h28);
        wr(9'h1F0, 8'hEE);
        peek(9'h1F1);
        check("ovf_status", rdata, 8'hA8);
        wr(9'h1F1, 8'h00);
        peek(9'h1F1);
        check("ovf_clear", rdata, 8'h28);
        tx_ready = 1'b1;
        wr(9'h1F0, 8'h55);
        tx_ready = 1'b0;
        peek(9'h1F1);
        check("full_pushpop_status", rdata, 8'h28);
        check("full_pushpop_head", tx_data, 8'h41);
        drain_all("ovf_drain");

        // Pointer wrap: 12 pushes interleaved with pops
        obs.delete();
        for (int i = 0; i < 12; i++) begin
            ab = 9'h1F0; wdata = 8'h60 + 8'(i); we = 1'b1; tx_ready = (i >= 2);
            check_outputs("wrap");
            step();
        end
        we = 1'b0;
        drain_all("wrap_drain");
        check("wrap_count", 16'(obs.size()), 16'd12);
        for (int i = 0; i < 12 && i < obs.size(); i++)
            check("wrap_order", obs[i], 8'h60 + 8'(i));

        // Reset mid-drain with queued bytes
        for (int i = 0; i < 5; i++) wr(9'h1F0, 8'h70 + 8'(i));
        tx_ready = 1'b1;
        step();
        step();
        ab = 9'h1F1;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_valid", tx_valid, 1'b0);
        check("midrst_data", tx_data, 8'h00);
        check("midrst_status", rdata, 8'h40);
        model_reset();
        tx_ready = 1'b0;
        @(posedge r_clk);
        #3;
        reset = 1'b0;
        #1;

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            kind = $urandom_range(0, 9);
            we = $urandom_range(0, 1);
            case (kind)
                0, 1:    ab = {1'b0, 8'($urandom)};
                2, 3:    ab = 9'h100 + 9'($urandom_range(0, 15));
                4, 5, 6: ab = 9'h1F0;
                7: begin
                    ab = 9'h1F1;
                    we = ($urandom_range(0, 3) == 0);
                end
                8:       ab = 9'h1F2 + 9'($urandom_range(0, 1));
                default: ab = 9'h1F0 + 9'($urandom_range(4, 15));
            endcase
            wdata    = 8'($urandom);
            rom_data = 8'($urandom);
            tx_ready = ($urandom_range(0, 2) == 0);
            check_outputs("rand");
            step();
        end
        we = 1'b0;
        drain_all("rand_drain");

        // Timer snapshot
        do_reset();
        ab = 9'h000;
        repeat (300) step();
        wr(9'h1F2, 8'h5A);
`ifdef BUS_MEM_IO_TIMER_EN
        peek(9'h1F2);
        check("tmr_lo", rdata, 8'h2C);
        peek(9'h1F3);
        check("tmr_hi", rdata, 8'h01);
`else
        peek(9'h1F2);
        check("tmr_lo_off", rdata, 8'h00);
        peek(9'h1F3);
        check("tmr_hi_off", rdata, 8'h00);
`endif
        check_outputs("tmr_model");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
